// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe - parametrised, pipelined integer ALU with valid/ready handshakes.
//
// An op is accepted when in_valid_i && in_ready_o. It is evaluated
// combinationally and captured into stage 0. It then moves through STAGES
// register stages and appears on the outputs STAGES cycles after acceptance,
// provided there are no stalls. Back-pressure from out_ready_i ripples backwards
// through a combinational advance chain, so a bubble anywhere in the pipe can
// be filled while the tail is stalled.
//
// Parameters
//   XLEN    operand/result width (16..64, power of two)
//   STAGES  pipeline register depth = no-stall latency (1..4)
//   TAG_W   width of the opaque tag carried with each op
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset (clears stage valid bits)
//   flush_i       drop every in-flight op at the next edge
//   in_valid_i    op presented
//   in_ready_o    op accepted this cycle when in_valid_i is also high
//   op_i          operation code
//   operand_a_i   operand A
//   operand_b_i   operand B
//   tag_i         transaction tag
//   out_valid_o   result available
//   out_ready_i   consumer takes the result this cycle
//   result_o      result (0 when out_valid_o is low)
//   branch_res_o  compare outcome of the branch ops (0 otherwise)
//   tag_o         tag of the op on result_o
//   busy_o        any stage holds a valid op
//
// Configuration
//   ALU_PIPE_ROT_EN  when defined, adds op 16 ROL, 17 ROR and 18 ANDN.
//                    When it is undefined, these codes behave as illegal ops
//                    (result 0) and no rotate logic is built.
//
// Only the stage valid bits are reset. The data registers never are; the
// outputs are forced to zero while the last stage is empty, so reset and flush
// cannot expose stale data.
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [4:0]       op_i,
  input  logic [XLEN-1:0]  operand_a_i,
  input  logic [XLEN-1:0]  operand_b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic             branch_res_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  localparam logic [4:0] OP_EQ   = 5'd10;
  localparam logic [4:0] OP_NE   = 5'd11;
  localparam logic [4:0] OP_LT   = 5'd12;
  localparam logic [4:0] OP_GE   = 5'd13;
  localparam logic [4:0] OP_LTU  = 5'd14;
  localparam logic [4:0] OP_GEU  = 5'd15;
`ifdef ALU_PIPE_ROT_EN
  localparam logic [4:0] OP_ROL  = 5'd16;
  localparam logic [4:0] OP_ROR  = 5'd17;
  localparam logic [4:0] OP_ANDN = 5'd18;
`endif

  // Evaluates one op and returns {branch_res, result}. The signed compares
  // use explicitly signed copies of the operands. The unsigned compares use
  // the raw vectors.
  function automatic logic [XLEN:0] alu_eval(
    input logic [4:0]      op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [SHW-1:0]         sh;
    logic [XLEN-1:0]        r;
    logic                   br;
    logic                   lt_s;
    logic                   lt_u;
    logic                   eq;
`ifdef ALU_PIPE_ROT_EN
    logic [2*XLEN-1:0]      dbl;
`endif
    a_s  = a;
    b_s  = b;
    sh   = b[SHW-1:0];
    r    = '0;
    br   = 1'b0;
    lt_s = a_s < b_s;
    lt_u = a < b;
    eq   = a == b;
`ifdef ALU_PIPE_ROT_EN
    dbl  = '0;
`endif
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = a_s >>> sh;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, lt_u};
      OP_EQ:   br = eq;
      OP_NE:   br = !eq;
      OP_LT:   br = lt_s;
      OP_GE:   br = !lt_s;
      OP_LTU:  br = lt_u;
      OP_GEU:  br = !lt_u;
`ifdef ALU_PIPE_ROT_EN
      // The rotates shift a doubled copy of A, so the bits that fall off one
      // end come back in at the other. A zero shift amount needs no special case.
      OP_ROL: begin
        dbl = {a, a} << sh;
        r   = dbl[2*XLEN-1:XLEN];
      end
      OP_ROR: begin
        dbl = {a, a} >> sh;
        r   = dbl[XLEN-1:0];
      end
      OP_ANDN: r = a & ~b;
`endif
      default: begin
        r  = '0;
        br = 1'b0;
      end
    endcase
    return {br, r};
  endfunction

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] adv;
  logic              gap;
  logic              accept;
  logic [XLEN:0]     alu_out;

  logic [XLEN-1:0]   res_p [STAGES];
  logic [STAGES-1:0] brc_p;
  logic [TAG_W-1:0]  tag_p [STAGES];

  // A stage advances when it or any later stage is empty, or when the
  // consumer takes the tail. The loop builds that chain from the tail
  // towards the head through a scalar accumulator, so no vector depends on
  // itself combinationally.
  always_comb begin
    adv = '0;
    gap = out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      gap    = gap || !vld_p[k];
      adv[k] = gap;
    end
  end

  // Ready stays high during a flush. Anything offered then is dropped by the
  // clearing of the valid bits.
  assign in_ready_o = adv[0] || flush_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign alu_out    = alu_eval(op_i, operand_a_i, operand_b_i);

  // Control: stage valid bits. Flush has priority over any handshake in the
  // same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      vld_p <= '0;
    end else begin
      if (adv[0]) begin
        vld_p[0] <= accept;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          vld_p[k] <= vld_p[k-1];
        end
      end
    end
  end

  // ---- stage boundary: combinational ALU -> stage 0 register ----
  always_ff @(posedge clk_i) begin
    if (adv[0]) begin
      res_p[0] <= alu_out[XLEN-1:0];
      brc_p[0] <= alu_out[XLEN];
      tag_p[0] <= tag_i;
    end
  end

  // ---- stage boundaries: stage k-1 -> stage k registers ----
  always_ff @(posedge clk_i) begin
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        res_p[k] <= res_p[k-1];
        brc_p[k] <= brc_p[k-1];
        tag_p[k] <= tag_p[k-1];
      end
    end
  end

  // ---- output boundary: last stage drives the ports, zeroed when empty ----
  assign out_valid_o  = vld_p[STAGES-1];
  assign result_o     = vld_p[STAGES-1] ? res_p[STAGES-1] : '0;
  assign branch_res_o = vld_p[STAGES-1] ? brc_p[STAGES-1] : 1'b0;
  assign tag_o        = vld_p[STAGES-1] ? tag_p[STAGES-1] : '0;
  assign busy_o       = |vld_p;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe - self-checking bench for alu_pipe (XLEN=32, STAGES=2, TAG_W=4).
// The first part is a directed sequence: reset, the op table, back-pressure,
// flush and mid-stream reset. The second part is a randomized run checked
// against a behavioural op model and an in-order scoreboard queue.
// -----------------------------------------------------------------------------
module tb_alu_pipe;
  localparam int XLEN   = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [4:0]       op_i;
  logic [XLEN-1:0]  operand_a_i;
  logic [XLEN-1:0]  operand_b_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  result_o;
  logic             branch_res_o;
  logic [TAG_W-1:0] tag_o;
  logic             busy_o;

  alu_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .op_i(op_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .branch_res_o(branch_res_o), .tag_o(tag_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_asrt = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] res;
    logic        br;
    logic [3:0]  tag;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference behaviour of one op, written from the op table with plain
  // 32-bit arithmetic.
  function automatic void model(input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic br);
    int sh;
    sh = int'(b[4:0]);
    r  = 32'd0;
    br = 1'b0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = a << sh;
      5'd6:  r = a >> sh;
      5'd7:  r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      5'd8:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      5'd9:  r = (a < b) ? 32'd1 : 32'd0;
      5'd10: br = (a == b);
      5'd11: br = (a != b);
      5'd12: br = (int'(a) < int'(b));
      5'd13: br = !(int'(a) < int'(b));
      5'd14: br = (a < b);
      5'd15: br = !(a < b);
`ifdef ALU_PIPE_ROT_EN
      5'd16: r = (a << sh) | (a >> (32 - sh));
      5'd17: r = (a >> sh) | (a << (32 - sh));
      5'd18: r = a & ~b;
`endif
      default: r = 32'd0;
    endcase
  endfunction

  // Issue one op with the consumer ready and check latency and outputs.
  task automatic issue_check(input string nm, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] tg,
                             input logic [31:0] er, input logic ebr);
    op_i = op; operand_a_i = a; operand_b_i = b; tag_i = tg;
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    #1;
    chk({nm, ".rdy"}, 64'(in_ready_o), 64'd1);
    tick();
    in_valid_i = 1'b0;
    chk({nm, ".lat1"}, 64'(out_valid_o), 64'd0);
    tick();
    chk({nm, ".vld"}, 64'(out_valid_o), 64'd1);
    chk({nm, ".res"}, 64'(result_o), 64'(er));
    chk({nm, ".br"},  64'(branch_res_o), 64'(ebr));
    chk({nm, ".tag"}, 64'(tag_o), 64'(tg));
  endtask

  logic [31:0] corners [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h7FFF_FFFF, 32'h1F, 32'h20, 32'h8000_0001};

  function automatic logic [31:0] pick();
    if ($urandom_range(3) == 0) return corners[$urandom_range(7)];
    return $urandom;
  endfunction

  initial begin
    logic        acc, pop, hold_prev, prev_br, e_br;
    logic [31:0] prev_res, e_res;
    logic [3:0]  prev_tag;
    exp_t        e;

    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    op_i = 5'd0; operand_a_i = '0; operand_b_i = '0; tag_i = '0;
    repeat (3) tick();
    chk("rst.vld", 64'(out_valid_o), 64'd0);
    chk("rst.res", 64'(result_o), 64'd0);
    chk("rst.br",  64'(branch_res_o), 64'd0);
    chk("rst.tag", 64'(tag_o), 64'd0);
    chk("rst.busy", 64'(busy_o), 64'd0);
    rst_i = 1'b0;
    #1;
    chk("rst.rdy", 64'(in_ready_o), 64'd1);

    // Op table, directed values
    issue_check("add",   5'd0,  32'h1234_5678, 32'h4567_89AB, 4'd3, 32'h579B_E023, 1'b0);
    issue_check("addw",  5'd0,  32'hFFFF_FFFF, 32'h1,         4'd1, 32'h0,         1'b0);
    issue_check("sub",   5'd1,  32'h0,         32'h1,         4'd2, 32'hFFFF_FFFF, 1'b0);
    issue_check("and",   5'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 4'd4, 32'h00F0_1200, 1'b0);
    issue_check("or",    5'd3,  32'hF000_0001, 32'h0000_1000, 4'd5, 32'hF000_1001, 1'b0);
    issue_check("xor",   5'd4,  32'hFFFF_0000, 32'hF0F0_F0F0, 4'd6, 32'h0F0F_F0F0, 1'b0);
    issue_check("sll",   5'd5,  32'h1,         32'h21,        4'd7, 32'h2,         1'b0);
    issue_check("sra",   5'd7,  32'h8000_0000, 32'h4,         4'd8, 32'hF800_0000, 1'b0);
    issue_check("srl",   5'd6,  32'h8000_0000, 32'h4,         4'd9, 32'h0800_0000, 1'b0);
    issue_check("lt",    5'd12, 32'hFFFF_FFFF, 32'h1,         4'd10, 32'h0,        1'b1);
    issue_check("ltu",   5'd14, 32'hFFFF_FFFF, 32'h1,         4'd11, 32'h0,        1'b0);
    issue_check("slt",   5'd8,  32'hFFFF_FFFF, 32'h1,         4'd12, 32'h1,        1'b0);
    issue_check("sltu",  5'd9,  32'hFFFF_FFFF, 32'h1,         4'd13, 32'h0,        1'b0);
    issue_check("eq",    5'd10, 32'h5,         32'h5,         4'd14, 32'h0,        1'b1);
    issue_check("ne",    5'd11, 32'h5,         32'h5,         4'd15, 32'h0,        1'b0);
    issue_check("ge",    5'd13, 32'hFFFF_FFFF, 32'h1,         4'd0, 32'h0,         1'b0);
    issue_check("geu",   5'd15, 32'hFFFF_FFFF, 32'h1,         4'd1, 32'h0,         1'b1);
`ifdef ALU_PIPE_ROT_EN
    issue_check("rol",   5'd16, 32'h8000_0001, 32'h1,         4'd2, 32'h0000_0003, 1'b0);
    issue_check("ror",   5'd17, 32'h8000_0001, 32'h1,         4'd3, 32'hC000_0000, 1'b0);
    issue_check("andn",  5'd18, 32'hFFFF_00FF, 32'h0000_000F, 4'd4, 32'hFFFF_00F0, 1'b0);
`else
    issue_check("op16",  5'd16, 32'h8000_0001, 32'h1,         4'd2, 32'h0,         1'b0);
`endif
    issue_check("ill31", 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 32'h0,         1'b0);

    // Back-pressure: tags 1,2,3 (ADD x+0) with the consumer stalled
    tick();
    out_ready_i = 1'b0; op_i = 5'd0; operand_b_i = 32'h0; in_valid_i = 1'b1;
    tag_i = 4'd1; operand_a_i = 32'h11;
    #1; chk("bp.rdy1", 64'(in_ready_o), 64'd1);
    tick();
    tag_i = 4'd2; operand_a_i = 32'h22;
    #1; chk("bp.rdy2", 64'(in_ready_o), 64'd1);
    tick();
    tag_i = 4'd3; operand_a_i = 32'h33;
    #1; chk("bp.rdy_drop", 64'(in_ready_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp.hold_vld", 64'(out_valid_o), 64'd1);
      chk("bp.hold_tag", 64'(tag_o), 64'd1);
      chk("bp.hold_res", 64'(result_o), 64'h11);
      chk("bp.hold_rdy", 64'(in_ready_o), 64'd0);
      tick();
    end
    out_ready_i = 1'b1;
    #1; chk("bp.rel_rdy", 64'(in_ready_o), 64'd1);
    tick();
    in_valid_i = 1'b0;
    chk("bp.t2", 64'({out_valid_o, tag_o, result_o}), 64'({1'b1, 4'd2, 32'h22}));
    tick();
    chk("bp.t3", 64'({out_valid_o, tag_o, result_o}), 64'({1'b1, 4'd3, 32'h33}));
    tick();
    chk("bp.empty", 64'(out_valid_o), 64'd0);

    // Flush with two ops in flight; an op offered during the flush is dropped
    out_ready_i = 1'b0; in_valid_i = 1'b1; op_i = 5'd1;
    operand_a_i = 32'h100; operand_b_i = 32'h1; tag_i = 4'd5;
    tick();
    tag_i = 4'd6;
    tick();
    in_valid_i = 1'b0;
    chk("fl.busy_pre", 64'(busy_o), 64'd1);
    chk("fl.vld_pre", 64'(out_valid_o), 64'd1);
    flush_i = 1'b1; out_ready_i = 1'b1; in_valid_i = 1'b1; tag_i = 4'd7;
    #1; chk("fl.rdy", 64'(in_ready_o), 64'd1);
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("fl.outs", 64'({out_valid_o, busy_o, branch_res_o, tag_o, result_o}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl.quiet", 64'({out_valid_o, busy_o}), 64'd0);
    end

    // Reset mid-stream
    out_ready_i = 1'b0; in_valid_i = 1'b1; op_i = 5'd12;
    operand_a_i = 32'hFFFF_FFFF; operand_b_i = 32'h1; tag_i = 4'd9;
    tick();
    tag_i = 4'd10;
    tick();
    in_valid_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mr.outs", 64'({out_valid_o, busy_o, branch_res_o, tag_o, result_o}), 64'd0);
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr.quiet", 64'(out_valid_o), 64'd0);
    end
    issue_check("mr.add", 5'd0, 32'h1234_5678, 32'h4567_89AB, 4'd3, 32'h579B_E023, 1'b0);
    tick();

    // Randomized traffic against the model and an in-order scoreboard
    hold_prev = 1'b0; prev_res = '0; prev_tag = '0; prev_br = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      in_valid_i  = ($urandom_range(9) < 7);
      out_ready_i = ($urandom_range(9) < 6);
      flush_i     = ($urandom_range(39) == 0);
      op_i        = ($urandom_range(7) == 0) ? 5'($urandom) : 5'($urandom_range(18));
      operand_a_i = pick();
      operand_b_i = pick();
      tag_i       = 4'($urandom);
      #1;
      if (hold_prev) begin
        chk("rnd.hold", 64'({out_valid_o, branch_res_o, tag_o, result_o}),
            64'({1'b1, prev_br, prev_tag, prev_res}));
      end
      acc = in_valid_i && in_ready_o;
      pop = out_valid_o && out_ready_i;
      if (flush_i) begin
        sbq.delete();
      end else begin
        if (pop) begin
          chk("rnd.qnonempty", 64'(sbq.size() > 0), 64'd1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rnd.out", 64'({branch_res_o, tag_o, result_o}), 64'({e.br, e.tag, e.res}));
          end
        end
        if (acc) begin
          model(op_i, operand_a_i, operand_b_i, e_res, e_br);
          e.res = e_res; e.br = e_br; e.tag = tag_i;
          sbq.push_back(e);
        end
      end
      chk("rnd.occ", 64'(sbq.size() <= STAGES), 64'd1);
      hold_prev = out_valid_o && !out_ready_i && !flush_i;
      prev_res = result_o; prev_tag = tag_o; prev_br = branch_res_o;
      tick();
    end

    // Drain, bounded
    in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid_o) begin
        chk("drain.qnonempty", 64'(sbq.size() > 0), 64'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("drain.out", 64'({branch_res_o, tag_o, result_o}), 64'({e.br, e.tag, e.res}));
        end
      end
      tick();
    end
    chk("drain.q", 64'(sbq.size()), 64'd0);
    chk("drain.vld", 64'({out_valid_o, busy_o}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
